spi_slave_syncro_hs: RTL and testbench
======================================

Name: spi_slave_syncro_hs

Overview:
Parametrised SPI-to-system-clock synchroniser for the AXI SPI slave. It brings chip-select, address-valid and rd/wr from the SPI clock domain into sys_clk through a configurable-depth synchroniser. It also emits one-cycle chip-select edge pulses. It captures address and rd_wr into a holding register and presents them to the AXI master FSM over a valid/ready handshake, with sticky overrun detection.

Parameters:
AXI_ADDR_WIDTH, 32, width of the address bus.
SYNC_STAGES, 2, flops per synchroniser chain; legal range 2..4.
CS_RESET_VAL, 1'b1, reset value loaded into every flop of the cs chain (idle-high chip select).

Ports:
sys_clk  input  1  system clock; all logic on rising edge.
rst  input  1  synchronous reset, active-high.
cs  input  1  asynchronous SPI chip select, active-low.
address  input  AXI_ADDR_WIDTH  SPI-domain address; quasi-static while address_valid is high.
address_valid  input  1  asynchronous level; rises once per address phase.
rd_wr  input  1  SPI-domain direction; quasi-static with address.
address_ready  input  1  consumer accepts the captured address.
overrun_clr  input  1  clears the overrun flag.
cs_sync  output  1  synchronised chip-select level.
cs_fall  output  1  one-cycle pulse: transaction start.
cs_rise  output  1  one-cycle pulse: transaction end.
address_sync  output  AXI_ADDR_WIDTH  captured address.
rd_wr_sync  output  1  captured direction.
address_valid_sync  output  1  captured address pending.
overrun  output  1  sticky: new address arrived while one was pending.

Behaviour:
- Reset (rst high at a clock edge): every cs chain flop and the cs edge flop take CS_RESET_VAL. Valid chain and valid edge flop take 0. Outputs after reset: cs_sync=CS_RESET_VAL, cs_fall=0, cs_rise=0, address_sync=0, rd_wr_sync=0, address_valid_sync=0, overrun=0.
- No edge pulse may be generated on the first cycle after reset.
- Reset mid-transaction drops the pending address without setting overrun.
- cs chain: SYNC_STAGES flops. cs_sync = last stage, so latency is SYNC_STAGES edges.
- One extra flop holds the previous cs_sync.
- cs_fall = previous & ~cs_sync; cs_rise = ~previous & cs_sync. Both are registered, so each pulse is exactly one cycle, one cycle after cs_sync changes.
- address_valid chain: SYNC_STAGES flops plus one edge flop.
- vrise (internal, combinational) = last stage & ~edge flop.
- Falling edges of address_valid are ignored.
- Capture/handshake, evaluated at each edge with rst low:
  - vrise and (address_valid_sync=0 or address_ready=1): load address_sync<=address and rd_wr_sync<=rd_wr; address_valid_sync<=1. A simultaneous accept plus new arrival is back-to-back: valid stays 1 with new data and no overrun.
  - vrise and address_valid_sync=1 and address_ready=0: overrun<=1; the held address and rd_wr are unchanged (new one dropped); valid stays 1.
  - no vrise and address_valid_sync=1 and address_ready=1: address_valid_sync<=0; data registers hold.
  - address_ready while address_valid_sync=0: no effect.
- Latency, SYNC_STAGES=2: address_valid sampled high at edge 1 -> last stage high at edge 2 -> vrise in cycle 2-3 -> address_valid_sync=1 after edge 3. In general SYNC_STAGES+1 edges.
- address_sync, rd_wr_sync and address_valid_sync change only together, or valid alone. Data never changes while valid=1 and ready=0.
- overrun: set per the rule above. Cleared when overrun_clr=1 and no set condition in the same cycle; a simultaneous set and clear leaves overrun=1.
- cs edges and the address handshake are independent; cs_rise does not flush a pending address.

Test Plan:
- Reset release with cs=1, address_valid=0 for 10 cycles -> cs_sync=1; cs_fall/cs_rise never pulse; address_valid_sync=0, overrun=0.
- SYNC_STAGES=2: drive cs 1->0 before edge k -> cs_sync=0 after edge k+1; cs_fall=1 for exactly the cycle after edge k+2. Return cs to 1 -> single cs_rise pulse.
- address=0xDEAD_BEEF, rd_wr=1, address_valid rises, address_ready=0 -> address_valid_sync=1 after 3 edges with address_sync=0xDEADBEEF, rd_wr_sync=1. Hold 5 cycles -> stable. Pulse address_ready for one cycle -> valid=0 next cycle, address_sync still 0xDEADBEEF.
- Pending 0x1000 not accepted; second address_valid pulse with 0x2000 -> overrun=1, address_sync stays 0x1000. overrun_clr and a third rise in the same cycle -> overrun stays 1. Later overrun_clr alone -> 0.
- Pending 0x1000; address_ready=1 in the same cycle vrise occurs for 0x3000 -> valid stays 1, address_sync=0x3000, overrun=0.
- Assert rst for one cycle while address_valid_sync=1 and cs chain=0 -> all outputs return to reset values; no cs_rise pulse emitted afterwards. Repeat with SYNC_STAGES=3 and confirm latency of 4 edges to address_valid_sync.

Source files
------------

// File: rtl/spi_slave_syncro_hs.sv
// SPI-to-sys_clk synchroniser for the AXI SPI slave.
// Brings cs / address_valid across through SYNC_STAGES-deep chains, emits
// registered cs edge pulses and hands the captured address + direction to
// the AXI master FSM over valid/ready with a sticky overrun flag.
// SYNC_STAGES must be in 2..4.
module spi_slave_syncro_hs #(
  parameter int   AXI_ADDR_WIDTH = 32,
  parameter int   SYNC_STAGES    = 2,
  parameter logic CS_RESET_VAL   = 1'b1
) (
  input  logic                      sys_clk,
  input  logic                      rst,
  input  logic                      cs,
  input  logic [AXI_ADDR_WIDTH-1:0] address,
  input  logic                      address_valid,
  input  logic                      rd_wr,
  input  logic                      address_ready,
  input  logic                      overrun_clr,
  output logic                      cs_sync,
  output logic                      cs_fall,
  output logic                      cs_rise,
  output logic [AXI_ADDR_WIDTH-1:0] address_sync,
  output logic                      rd_wr_sync,
  output logic                      address_valid_sync,
  output logic                      overrun
);

  logic [SYNC_STAGES-1:0]    cs_pipe_q;
  logic                      cs_prev_q;
  logic                      cs_fall_q, cs_rise_q;
  logic [SYNC_STAGES-1:0]    av_pipe_q;
  logic                      av_edge_q;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                      rdwr_q, rdwr_d;
  logic                      valid_q, valid_d;
  logic                      ovr_q, ovr_d;
  logic                      vrise;
  logic                      ovr_set;

  // cs synchroniser plus registered edge detection; the prev flop resets to
  // the same idle level as the chain so no pulse can appear after reset
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      cs_pipe_q <= {SYNC_STAGES{CS_RESET_VAL}};
      cs_prev_q <= CS_RESET_VAL;
      cs_fall_q <= 1'b0;
      cs_rise_q <= 1'b0;
    end else begin
      cs_pipe_q <= {cs_pipe_q[SYNC_STAGES-2:0], cs};
      cs_prev_q <= cs_pipe_q[SYNC_STAGES-1];
      cs_fall_q <= cs_prev_q & ~cs_pipe_q[SYNC_STAGES-1];
      cs_rise_q <= ~cs_prev_q & cs_pipe_q[SYNC_STAGES-1];
    end
  end

  // address_valid synchroniser; only its rising edge matters
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      av_pipe_q <= '0;
      av_edge_q <= 1'b0;
    end else begin
      av_pipe_q <= {av_pipe_q[SYNC_STAGES-2:0], address_valid};
      av_edge_q <= av_pipe_q[SYNC_STAGES-1];
    end
  end

  assign vrise = av_pipe_q[SYNC_STAGES-1] & ~av_edge_q;

  // capture / handshake: accept-and-refill in one cycle is legal; an arrival
  // while the slot is held and not accepted is dropped and flagged
  always_comb begin
    addr_d  = addr_q;
    rdwr_d  = rdwr_q;
    valid_d = valid_q;
    ovr_set = 1'b0;
    if (vrise) begin
      if (!valid_q || address_ready) begin
        addr_d  = address;
        rdwr_d  = rd_wr;
        valid_d = 1'b1;
      end else begin
        ovr_set = 1'b1;
      end
    end else if (valid_q && address_ready) begin
      valid_d = 1'b0;
    end
    // set wins over a simultaneous clear
    if (ovr_set)          ovr_d = 1'b1;
    else if (overrun_clr) ovr_d = 1'b0;
    else                  ovr_d = ovr_q;
  end

  // holding register and overrun flag
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      addr_q  <= '0;
      rdwr_q  <= 1'b0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      rdwr_q  <= rdwr_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign cs_sync            = cs_pipe_q[SYNC_STAGES-1];
  assign cs_fall            = cs_fall_q;
  assign cs_rise            = cs_rise_q;
  assign address_sync       = addr_q;
  assign rd_wr_sync         = rdwr_q;
  assign address_valid_sync = valid_q;
  assign overrun            = ovr_q;

endmodule

// File: tb/tb_spi_slave_syncro_hs.sv
// Directed bench: stimulus pushes expected captures into a queue, a monitor
// pops/compares whenever the DUT presents a new address.
module tb_spi_slave_syncro_hs;

  typedef struct packed {
    logic [31:0] a;
    logic        rw;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, cs, address_valid, rd_wr, address_ready, overrun_clr;
  logic [31:0] address;

  logic        cs_sync, cs_fall, cs_rise, rd_wr_sync, address_valid_sync, overrun;
  logic [31:0] address_sync;
  logic        cs_sync3, cs_fall3, cs_rise3, rd_wr_sync3, avs3, overrun3;
  logic [31:0] address_sync3;

  int checks   = 0;
  int failures = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  spi_slave_syncro_hs #(.AXI_ADDR_WIDTH(32), .SYNC_STAGES(2), .CS_RESET_VAL(1'b1)) dut (
    .sys_clk(clk), .rst(rst), .cs(cs), .address(address),
    .address_valid(address_valid), .rd_wr(rd_wr), .address_ready(address_ready),
    .overrun_clr(overrun_clr), .cs_sync(cs_sync), .cs_fall(cs_fall),
    .cs_rise(cs_rise), .address_sync(address_sync), .rd_wr_sync(rd_wr_sync),
    .address_valid_sync(address_valid_sync), .overrun(overrun));

  spi_slave_syncro_hs #(.AXI_ADDR_WIDTH(32), .SYNC_STAGES(3), .CS_RESET_VAL(1'b1)) dut3 (
    .sys_clk(clk), .rst(rst), .cs(cs), .address(address),
    .address_valid(address_valid), .rd_wr(rd_wr), .address_ready(address_ready),
    .overrun_clr(overrun_clr), .cs_sync(cs_sync3), .cs_fall(cs_fall3),
    .cs_rise(cs_rise3), .address_sync(address_sync3), .rd_wr_sync(rd_wr_sync3),
    .address_valid_sync(avs3), .overrun(overrun3));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, ".cs_sync"}, cs_sync, 1'b1);
    chk({tag, ".cs_fall"}, cs_fall, 1'b0);
    chk({tag, ".cs_rise"}, cs_rise, 1'b0);
    chk({tag, ".addr"},    address_sync, 32'h0);
    chk({tag, ".rd_wr"},   rd_wr_sync, 1'b0);
    chk({tag, ".valid"},   address_valid_sync, 1'b0);
    chk({tag, ".overrun"}, overrun, 1'b0);
  endtask

  // monitor: a presentation is valid rising, or data changing while valid
  logic        pv = 1'b0;
  logic [31:0] pa = '0;
  logic        prw = 1'b0;
  always @(posedge clk) begin
    #2;
    if (address_valid_sync === 1'b1 &&
        (!pv || address_sync !== pa || rd_wr_sync !== prw)) begin
      if (exp_q.size() == 0) begin
        chk("mon.unexpected_capture", {rd_wr_sync, address_sync}, 64'hx);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("mon.address_sync", address_sync, e.a);
        chk("mon.rd_wr_sync", rd_wr_sync, e.rw);
      end
    end
    pv  = address_valid_sync;
    pa  = address_sync;
    prw = rd_wr_sync;
  end

  // raises address_valid, runs to the capture edge (3 edges for depth 2)
  task automatic raise_av(input logic [31:0] a, input logic rw, input bit expect_capture);
    address = a;
    rd_wr = rw;
    address_valid = 1'b1;
    if (expect_capture) exp_q.push_back('{a: a, rw: rw});
    tick(3);
  endtask

  task automatic drop_av();
    address_valid = 1'b0;
    tick(3);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    rst = 1'b1; cs = 1'b1; address_valid = 1'b0; rd_wr = 1'b0;
    address_ready = 1'b0; overrun_clr = 1'b0; address = '0;
    tick(2);
    chk_reset_outs("rst");
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle.cs_sync", cs_sync, 1'b1);
      chk("idle.pulses", {cs_fall, cs_rise}, 2'b00);
      chk("idle.valid_ovr", {address_valid_sync, overrun}, 2'b00);
    end

    // cs falling then rising, depth 2
    cs = 1'b0;
    tick(); chk("csf.k.cs_sync", cs_sync, 1'b1);
    tick(); chk("csf.k1.cs_sync", cs_sync, 1'b0); chk("csf.k1.fall", cs_fall, 1'b0);
    tick(); chk("csf.k2.fall", cs_fall, 1'b1); chk("csf.k2.rise", cs_rise, 1'b0);
    tick(); chk("csf.k3.fall", cs_fall, 1'b0);
    cs = 1'b1;
    tick(); chk("csr.k.cs_sync", cs_sync, 1'b0);
    tick(); chk("csr.k1.cs_sync", cs_sync, 1'b1); chk("csr.k1.rise", cs_rise, 1'b0);
    tick(); chk("csr.k2.rise", cs_rise, 1'b1); chk("csr.k2.fall", cs_fall, 1'b0);
    tick(); chk("csr.k3.rise", cs_rise, 1'b0);

    // basic capture with latency 3 and hold under ready=0
    address = 32'hDEAD_BEEF; rd_wr = 1'b1; address_valid = 1'b1;
    exp_q.push_back('{a: 32'hDEAD_BEEF, rw: 1'b1});
    tick(); chk("cap.e1.valid", address_valid_sync, 1'b0);
    tick(); chk("cap.e2.valid", address_valid_sync, 1'b0);
    tick(); chk("cap.e3.valid", address_valid_sync, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold.valid", address_valid_sync, 1'b1);
      chk("hold.addr", address_sync, 32'hDEAD_BEEF);
    end
    address_valid = 1'b0; address = 32'h0; rd_wr = 1'b0;
    tick(3);
    chk("fall_ignored.valid", address_valid_sync, 1'b1);
    chk("fall_ignored.addr", address_sync, 32'hDEAD_BEEF);
    address_ready = 1'b1;
    tick(); address_ready = 1'b0;
    chk("accept.valid", address_valid_sync, 1'b0);
    chk("accept.addr_held", address_sync, 32'hDEAD_BEEF);
    tick();
    chk("ready_idle.valid", address_valid_sync, 1'b0);

    // overrun: second arrival while pending is dropped
    raise_av(32'h1000, 1'b0, 1'b1);
    drop_av();
    raise_av(32'h2000, 1'b1, 1'b0);
    chk("ovr.set", overrun, 1'b1);
    chk("ovr.addr_kept", address_sync, 32'h1000);
    chk("ovr.rw_kept", rd_wr_sync, 1'b0);
    drop_av();
    address = 32'h4000; address_valid = 1'b1;
    tick(2);
    overrun_clr = 1'b1;
    tick(); overrun_clr = 1'b0;
    chk("ovr.set_beats_clr", overrun, 1'b1);
    chk("ovr.addr_kept2", address_sync, 32'h1000);
    drop_av();
    overrun_clr = 1'b1;
    tick(); overrun_clr = 1'b0;
    chk("ovr.cleared", overrun, 1'b0);
    chk("ovr.valid_still", address_valid_sync, 1'b1);

    // back-to-back: accept 0x1000 on the same edge 0x3000 arrives
    address = 32'h3000; rd_wr = 1'b1; address_valid = 1'b1;
    exp_q.push_back('{a: 32'h3000, rw: 1'b1});
    tick(2);
    address_ready = 1'b1;
    tick(); address_ready = 1'b0;
    chk("b2b.valid", address_valid_sync, 1'b1);
    chk("b2b.addr", address_sync, 32'h3000);
    chk("b2b.overrun", overrun, 1'b0);
    address_ready = 1'b1;
    tick(); address_ready = 1'b0;
    chk("b2b.accept", address_valid_sync, 1'b0);
    drop_av();

    // reset while pending and cs low
    cs = 1'b0;
    raise_av(32'h5000, 1'b0, 1'b1);
    address_valid = 1'b0;
    tick(2);
    chk("pre_rst.cs_sync", cs_sync, 1'b0);
    chk("pre_rst.valid", address_valid_sync, 1'b1);
    rst = 1'b1; cs = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_outs("midrst");
    chk("midrst3.state", {cs_sync3, cs_fall3, cs_rise3, avs3, overrun3, rd_wr_sync3}, 6'b100000);
    chk("midrst3.addr", address_sync3, 32'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("post_rst.pulses", {cs_fall, cs_rise}, 2'b00);
      chk("post_rst.ovr_valid", {overrun, address_valid_sync}, 2'b00);
    end

    // latency: depth 2 -> 3 edges, depth 3 -> 4 edges
    address = 32'h6000; rd_wr = 1'b1; address_valid = 1'b1;
    exp_q.push_back('{a: 32'h6000, rw: 1'b1});
    lat = 0;
    while (avs3 !== 1'b1 && lat < 10) begin
      tick();
      lat++;
      if (lat == 3) chk("lat2.valid_at3", address_valid_sync, 1'b1);
    end
    chk("lat3.edges", lat, 4);
    chk("lat3.addr", address_sync3, 32'h6000);
    chk("lat3.rw", rd_wr_sync3, 1'b1);
    address_valid = 1'b0;
    tick(3);
    chk("sb.drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
